peripheral_uart_rfifo_param: RTL

Parametrised UART receive FIFO, successor to the fixed 16x(8+3) receive FIFO. Stores received characters together with their per-character error flags (break, framing, parity). Sits between the UART receiver shift logic and the Wishbone register file. Adds a programmable trigger level, an exact error-entry counter and sticky overrun/underrun status.

---
 rtl/peripheral_uart_rfifo_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/peripheral_uart_rfifo_param.sv
// UART receive FIFO: characters with per-entry error flags, trigger level,
// exact error-entry count and sticky overrun/underrun status.
module peripheral_uart_rfifo_param #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 3,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     wb_rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W+ERR_W-1:0]  data_in,
    input  logic                     fifo_reset,
    input  logic                     reset_status,
    input  logic [CNT_W-1:0]         trig_level,
    output logic [DATA_W+ERR_W-1:0]  data_out,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full,
    output logic                     trig_hit,
    output logic                     overrun,
    output logic                     underrun,
    output logic                     error_bit,
    output logic [CNT_W-1:0]         err_count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_chr [DEPTH];
    logic [ERR_W-1:0]  mem_err [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  err_q;
    logic              overrun_q;
    logic              underrun_q;
    logic              flush;
    logic              wr_en;
    logic              rd_en;
    logic              in_err;
    logic              head_err;

    assign flush    = wb_rst_i || fifo_reset;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign rd_en    = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign wr_en    = push && (!full || rd_en);
    assign in_err   = |data_in[ERR_W-1:0];
    assign head_err = |mem_err[rd_ptr];

    assign data_out  = {mem_chr[rd_ptr], mem_err[rd_ptr]};
    assign count     = count_q;
    assign err_count = err_q;
    assign error_bit = (err_q != '0);
    assign trig_hit  = (trig_level != '0) && (count_q >= trig_level);
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_chr[wr_ptr] <= data_in[DATA_W+ERR_W-1:ERR_W];
        end
    end

    // Clear on pop first so a write to the same slot takes precedence.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_err[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                mem_err[rd_ptr] <= '0;
            end
            if (wr_en) begin
                mem_err[wr_ptr] <= data_in[ERR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            case ({wr_en && in_err, rd_en && head_err})
                2'b10:   err_q <= err_q + CNT_W'(1);
                2'b01:   err_q <= err_q - CNT_W'(1);
                default: err_q <= err_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= (overrun_q && !reset_status) || (push && full && !rd_en);
            underrun_q <= (underrun_q && !reset_status) || (pop && empty);
        end
    end

endmodule
